// File: rtl/logic_op_pkg.sv
// Shared types and the bitwise evaluation function for the logic-op arbiter.
package logic_op_pkg;

  typedef enum logic [2:0] {
    OP_AND     = 3'd0,
    OP_OR      = 3'd1,
    OP_NAND    = 3'd2,
    OP_NOR     = 3'd3,
    OP_XOR     = 3'd4,
    OP_XNOR    = 3'd5,
    OP_NOT_A   = 3'd6,
    OP_ILLEGAL = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  // One result bit for one operand bit pair; the datapath applies it across
  // the full operand width, which keeps the function independent of WIDTH.
  // The illegal opcode yields 0 so an erroring result is all zeros.
  function automatic logic logic_eval(op_e op, logic a, logic b);
    logic r;
    case (op)
      OP_AND:   r = a & b;
      OP_OR:    r = a | b;
      OP_NAND:  r = ~(a & b);
      OP_NOR:   r = ~(a | b);
      OP_XOR:   r = a ^ b;
      OP_XNOR:  r = ~(a ^ b);
      OP_NOT_A: r = ~a;
      default:  r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the lowest requesting index at or after
// ptr_i wins, wrapping from N-1 back to 0.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             any_o
);

  logic [N-1:0]   rot;
  logic [IDX_W:0] off;
  logic [IDX_W:0] win;

  // Rotate requests so the pointer sits at bit 0, pick the first set bit,
  // then rotate the offset back into an absolute index.
  always_comb begin
    rot   = N'({req_i, req_i} >> ptr_i);
    off   = '0;
    any_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off   = (IDX_W + 1)'(i);
        any_o = 1'b1;
      end
    end
    win = {1'b0, ptr_i} + off;
    if (win >= (IDX_W + 1)'(N)) begin
      win = win - (IDX_W + 1)'(N);
    end
    gnt_idx_o = win[IDX_W-1:0];
    for (int i = 0; i < N; i++) begin
      gnt_o[i] = any_o && (win == (IDX_W + 1)'(i));
    end
  end

endmodule

// File: rtl/logic_op_arbiter.sv
// Shares one registered bitwise logic unit among NUM_REQ requesters with
// round-robin arbitration and a single operation in flight (IDLE/EXEC/RESP).
module logic_op_arbiter
  import logic_op_pkg::*;
#(
  parameter int  NUM_REQ = 4,
  parameter int  WIDTH   = 8,
  localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*3-1:0]     req_op,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_data,
  output logic [ID_W-1:0]          rsp_id,
  output logic                     rsp_err,
  output logic                     busy
);

  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_idx;
  logic               any_req;
  logic               accept;

  state_e             state_q;
  logic [ID_W-1:0]    ptr_q;
  logic [ID_W-1:0]    ptr_d;

  op_e                op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [ID_W-1:0]    id_q;

  logic [2:0]         sel_op;
  logic [WIDTH-1:0]   sel_a;
  logic [WIDTH-1:0]   sel_b;

  logic [WIDTH-1:0]   res_d;
  logic               err_d;

  logic               rsp_valid_q;
  logic [WIDTH-1:0]   rsp_data_q;
  logic [ID_W-1:0]    rsp_id_q;
  logic               rsp_err_q;
  logic               busy_q;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (ID_W)
  ) u_rr (
    .req_i     (req_valid),
    .ptr_i     (ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .any_o     (any_req)
  );

  assign accept = (state_q == IDLE) && any_req;

  // Grant is only offered while idle; gating with rst_n keeps every output
  // at zero for the whole time reset is asserted.
  assign req_ready = (rst_n && (state_q == IDLE)) ? gnt : '0;

  // One-hot mux of the granted requester's opcode and operands.
  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_op = sel_op | req_op[3*i +: 3];
        sel_a  = sel_a  | req_a[WIDTH*i +: WIDTH];
        sel_b  = sel_b  | req_b[WIDTH*i +: WIDTH];
      end
    end
  end

  // Pointer advances to the slot just after the winner, wrapping at NUM_REQ.
  always_comb begin
    if (gnt_idx == ID_W'(NUM_REQ - 1)) begin
      ptr_d = '0;
    end else begin
      ptr_d = gnt_idx + ID_W'(1);
    end
  end

  // Bitwise evaluation of the latched operation.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      res_d[i] = logic_eval(op_q, a_q[i], b_q[i]);
    end
    err_d = (op_q == OP_ILLEGAL);
  end

  // Operand capture on the accept edge; never read before the first accept,
  // so it carries no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q <= op_e'(sel_op);
      a_q  <= sel_a;
      b_q  <= sel_b;
      id_q <= gnt_idx;
    end
  end

  // Control FSM with registered response outputs; reset drops any in-flight op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            ptr_q   <= ptr_d;
            busy_q  <= 1'b1;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          rsp_data_q  <= res_d;
          rsp_err_q   <= err_d;
          rsp_id_q    <= id_q;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Directed self-checking bench for logic_op_arbiter (NUM_REQ=4, WIDTH=8).
module tb_logic_op_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [11:0] req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_data;
  logic [1:0]  rsp_id;
  logic        rsp_err;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  logic_op_arbiter #(.NUM_REQ(4), .WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  // Protocol monitors: requests held until ready, response held until taken.
  logic [3:0] pv = '0;
  logic [3:0] pr = '0;
  logic       pvld = 1'b0;
  logic       prdy = 1'b0;
  logic       prst = 1'b0;
  always @(negedge clk) begin
    if (rst_n && prst) begin
      for (int i = 0; i < 4; i++) begin
        if (pv[i] && !pr[i] && !req_valid[i]) begin
          n_checks++; n_fail++;
          $display("FAIL req_hold[%0d]: valid got 0, required 1 until ready", i);
        end
      end
      if (pvld && !prdy && !rsp_valid) begin
        n_checks++; n_fail++;
        $display("FAIL rsp_hold: rsp_valid got 0, required 1 until handshake");
      end
    end
    pv = req_valid; pr = req_ready; pvld = rsp_valid; prdy = rsp_ready; prst = rst_n;
  end

  task automatic step(output logic [3:0] acc);
    @(negedge clk);
    acc = req_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    req_op[3*i +: 3] = op;
    req_a[8*i +: 8]  = a;
    req_b[8*i +: 8]  = b;
    req_valid[i]     = 1'b1;
  endtask

  task automatic apply_reset();
    req_valid = '0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Accept edge, EXEC edge, handshake edge (rsp_ready must be 1).
  task automatic run_txn(input bit drop, output logic [3:0] acc, output logic [3:0] acc_rest,
                         output logic v_exec, output logic v_rsp, output logic [7:0] d,
                         output logic [1:0] id, output logic e);
    logic [3:0] a1, a2;
    step(acc);
    v_exec = rsp_valid;
    if (drop) req_valid = req_valid & ~acc;
    step(a1);
    v_rsp = rsp_valid; d = rsp_data; id = rsp_id; e = rsp_err;
    step(a2);
    acc_rest = a1 | a2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 4'b0010; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid: got %b, required 0", rsp_valid); end
    n_checks++; if (rsp_data !== 8'h00) begin n_fail++; $display("FAIL rst_rsp_data: got %h, required 00", rsp_data); end
    n_checks++; if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL rst_rsp_id: got %0d, required 0", rsp_id); end
    n_checks++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_err: got %b, required 0", rsp_err); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b, required 0", busy); end
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL rst_req_ready: got %b, required 0000", req_ready); end
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_idle_busy: got %b, required 0", busy); end
  endtask

  task automatic test_basic();
    logic [3:0] acc;
    set_req(0, 3'd0, 8'hF0, 8'h3C);
    rsp_ready = 1'b1;
    step(acc);
    n_checks++; if (acc !== 4'b0001) begin n_fail++; $display("FAIL basic_grant: got %b, required 0001", acc); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %b, required 0", rsp_valid); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b, required 1", busy); end
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL basic_exec_ready: got %b, required 0000", req_ready); end
    req_valid[0] = 1'b0;
    step(acc);
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b, required 1", rsp_valid); end
    n_checks++; if (rsp_data !== 8'h30) begin n_fail++; $display("FAIL basic_data: got %h, required 30", rsp_data); end
    n_checks++; if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL basic_id: got %0d, required 0", rsp_id); end
    n_checks++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL basic_err: got %b, required 0", rsp_err); end
    step(acc);
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL basic_done_valid: got %b, required 0", rsp_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_done_busy: got %b, required 0", busy); end
  endtask

  task automatic test_round_robin();
    int         order[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    logic [7:0] xr[4]    = '{8'hED, 8'hCB, 8'hA9, 8'h87};
    logic [3:0] acc, rest, exp_oh;
    logic       ve, vr, e;
    logic [7:0] d;
    logic [1:0] id;
    apply_reset();
    set_req(0, 3'd4, 8'h12, 8'hFF);
    set_req(1, 3'd4, 8'h34, 8'hFF);
    set_req(2, 3'd4, 8'h56, 8'hFF);
    set_req(3, 3'd4, 8'h78, 8'hFF);
    rsp_ready = 1'b1;
    for (int g = 0; g < 8; g++) begin
      exp_oh = 4'b0001 << order[g];
      run_txn(g >= 4, acc, rest, ve, vr, d, id, e);
      n_checks++; if (acc !== exp_oh) begin n_fail++; $display("FAIL rr_grant[%0d]: got %b, required %b", g, acc, exp_oh); end
      n_checks++; if (rest !== 4'b0000) begin n_fail++; $display("FAIL rr_spacing[%0d]: got %b, required 0000", g, rest); end
      n_checks++; if (ve !== 1'b0) begin n_fail++; $display("FAIL rr_early[%0d]: got %b, required 0", g, ve); end
      n_checks++; if (vr !== 1'b1) begin n_fail++; $display("FAIL rr_valid[%0d]: got %b, required 1", g, vr); end
      n_checks++; if (id !== 2'(order[g])) begin n_fail++; $display("FAIL rr_id[%0d]: got %0d, required %0d", g, id, order[g]); end
      n_checks++; if (d !== xr[order[g]]) begin n_fail++; $display("FAIL rr_data[%0d]: got %h, required %h", g, d, xr[order[g]]); end
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] acc, rest;
    logic       ve, vr, e;
    logic [7:0] d;
    logic [1:0] id;
    set_req(1, 3'd1, 8'h0F, 8'h50);
    set_req(3, 3'd5, 8'hAA, 8'h0F);
    rsp_ready = 1'b0;
    step(acc);
    n_checks++; if (acc !== 4'b0010) begin n_fail++; $display("FAIL bp_grant: got %b, required 0010", acc); end
    req_valid[1] = 1'b0;
    step(acc);
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid: got %b, required 1", rsp_valid); end
    for (int k = 0; k < 5; k++) begin
      step(acc);
      n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid[%0d]: got %b, required 1", k, rsp_valid); end
      n_checks++; if (rsp_data !== 8'h5F) begin n_fail++; $display("FAIL bp_hold_data[%0d]: got %h, required 5F", k, rsp_data); end
      n_checks++; if (rsp_id !== 2'd1) begin n_fail++; $display("FAIL bp_hold_id[%0d]: got %0d, required 1", k, rsp_id); end
      n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_ready[%0d]: got %b, required 0000", k, req_ready); end
      n_checks++; if (acc !== 4'b0000) begin n_fail++; $display("FAIL bp_grant_hold[%0d]: got %b, required 0000", k, acc); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL bp_busy[%0d]: got %b, required 1", k, busy); end
    end
    rsp_ready = 1'b1;
    step(acc);
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release: got %b, required 0", rsp_valid); end
    n_checks++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL bp_next_ready: got %b, required 1000", req_ready); end
    run_txn(1'b1, acc, rest, ve, vr, d, id, e);
    n_checks++; if (acc !== 4'b1000) begin n_fail++; $display("FAIL bp_grant3: got %b, required 1000", acc); end
    n_checks++; if (d !== 8'h5A) begin n_fail++; $display("FAIL bp_data3: got %h, required 5A", d); end
    n_checks++; if (id !== 2'd3) begin n_fail++; $display("FAIL bp_id3: got %0d, required 3", id); end
  endtask

  task automatic test_illegal();
    logic [3:0] acc, rest;
    logic       ve, vr, e;
    logic [7:0] d;
    logic [1:0] id;
    set_req(2, 3'd7, 8'hFF, 8'hFF);
    run_txn(1'b1, acc, rest, ve, vr, d, id, e);
    n_checks++; if (acc !== 4'b0100) begin n_fail++; $display("FAIL ill_grant: got %b, required 0100", acc); end
    n_checks++; if (vr !== 1'b1) begin n_fail++; $display("FAIL ill_valid: got %b, required 1", vr); end
    n_checks++; if (e !== 1'b1) begin n_fail++; $display("FAIL ill_err: got %b, required 1", e); end
    n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL ill_data: got %h, required 00", d); end
    n_checks++; if (id !== 2'd2) begin n_fail++; $display("FAIL ill_id: got %0d, required 2", id); end
    set_req(2, 3'd3, 8'h00, 8'h0F);
    run_txn(1'b1, acc, rest, ve, vr, d, id, e);
    n_checks++; if (acc !== 4'b0100) begin n_fail++; $display("FAIL nor_grant: got %b, required 0100", acc); end
    n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL nor_err: got %b, required 0", e); end
    n_checks++; if (d !== 8'hF0) begin n_fail++; $display("FAIL nor_data: got %h, required F0", d); end
  endtask

  task automatic test_wrap();
    logic [3:0] acc, rest;
    logic       ve, vr, e;
    logic [7:0] d;
    logic [1:0] id;
    set_req(1, 3'd0, 8'hC3, 8'h0F);
    set_req(3, 3'd6, 8'h5A, 8'hFF);
    run_txn(1'b1, acc, rest, ve, vr, d, id, e);
    n_checks++; if (acc !== 4'b1000) begin n_fail++; $display("FAIL wrap_first: got %b, required 1000", acc); end
    n_checks++; if (d !== 8'hA5) begin n_fail++; $display("FAIL wrap_not_data: got %h, required A5", d); end
    n_checks++; if (id !== 2'd3) begin n_fail++; $display("FAIL wrap_id3: got %0d, required 3", id); end
    run_txn(1'b1, acc, rest, ve, vr, d, id, e);
    n_checks++; if (acc !== 4'b0010) begin n_fail++; $display("FAIL wrap_second: got %b, required 0010", acc); end
    n_checks++; if (d !== 8'h03) begin n_fail++; $display("FAIL wrap_and_data: got %h, required 03", d); end
    n_checks++; if (id !== 2'd1) begin n_fail++; $display("FAIL wrap_id1: got %0d, required 1", id); end
  endtask

  task automatic test_reset_exec();
    logic [3:0] acc, rest;
    logic       ve, vr, e;
    logic [7:0] d;
    logic [1:0] id;
    set_req(2, 3'd4, 8'h55, 8'h0F);
    step(acc);
    n_checks++; if (acc !== 4'b0100) begin n_fail++; $display("FAIL rx_grant: got %b, required 0100", acc); end
    req_valid = '0;
    rst_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rx_busy: got %b, required 0", busy); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rx_valid: got %b, required 0", rsp_valid); end
    n_checks++; if (rsp_data !== 8'h00) begin n_fail++; $display("FAIL rx_data: got %h, required 00", rsp_data); end
    n_checks++; if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL rx_id: got %0d, required 0", rsp_id); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(acc);
      n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rx_no_rsp[%0d]: got %b, required 0", k, rsp_valid); end
    end
    set_req(0, 3'd0, 8'hFF, 8'h81);
    set_req(3, 3'd1, 8'h01, 8'h02);
    run_txn(1'b1, acc, rest, ve, vr, d, id, e);
    n_checks++; if (acc !== 4'b0001) begin n_fail++; $display("FAIL rx_next_grant: got %b, required 0001", acc); end
    n_checks++; if (d !== 8'h81) begin n_fail++; $display("FAIL rx_next_data: got %h, required 81", d); end
    run_txn(1'b1, acc, rest, ve, vr, d, id, e);
    n_checks++; if (acc !== 4'b1000) begin n_fail++; $display("FAIL rx_grant3: got %b, required 1000", acc); end
    n_checks++; if (d !== 8'h03) begin n_fail++; $display("FAIL rx_data3: got %h, required 03", d); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_backpressure();
    test_illegal();
    test_wrap();
    test_reset_exec();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

endmodule
